fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one 8-bit FIFO write port among NREQ producers.
//  Grants one requester at a time for a burst of up to BURST_MAX beats.
//  Drives the FIFO write enable and data directly, and stalls on FULL.
//  Sits between the producer blocks and the FIFO write side.
// PARAMETERS
//  NREQ       4   number of requesters (2..8)
//  DW         8   data width per beat
//  BURST_MAX  4   max beats per grant (>=1)
//  STALL_MAX  8   idle-grant timeout in cycles (used only with FIFO_ARB_STALL_TIMEOUT_EN)
// PORTS
//  SYSCLK      in   1         clock, all state on rising edge
//  RST_B       in   1         reset, synchronous, active-low
//  REQ         in   NREQ      per-requester beat valid
//  REQ_DATA    in   NREQ*DW   requester i data at [i*DW +: DW]
//  REQ_LAST    in   NREQ      final beat of requester's burst
//  FIFO_FULL   in   1         FIFO full flag
//  GNT         out  NREQ      registered one-hot grant
//  GNT_ID      out  clog2(NREQ)  index of granted requester (valid when |GNT)
//  ACK         out  NREQ      beat accepted this cycle (combinational)
//  FIFO_WR_EN  out  1         FIFO write strobe
//  FIFO_DIN    out  DW        FIFO write data
//  STALL_ERR   out  1         1-cycle pulse on timeout release (tied 0 without the macro)
// BEHAVIOUR
//  Reset (RST_B=0 at edge): state=IDLE, GNT=0, GNT_ID=0, beat_cnt=0, last_ptr=NREQ-1, STALL_ERR=0.
//   FIFO_WR_EN and ACK are forced 0 while RST_B=0. Reset mid-burst abandons the burst.
//  FSM IDLE:
//   - If |REQ, pick the first set REQ searching last_ptr+1, +2, ... mod NREQ.
//   - Next edge: GNT=onehot(pick), GNT_ID=pick, beat_cnt=0, go to BURST.
//   - No writes occur in IDLE.
//  FSM BURST:
//   - beat = REQ[g] & ~FIFO_FULL; FIFO_WR_EN=beat; ACK[g]=beat; FIFO_DIN=REQ_DATA[g].
//   - On beat: beat_cnt++. If REQ_LAST[g] or beat_cnt==BURST_MAX-1: next edge go to IDLE,
//     GNT=0, last_ptr=g.
//   - FULL stall: grant held, no beat, beat_cnt unchanged.
//   - REQ[g]=0 mid-burst: grant held (burst lock) unless the timeout feature is enabled.
//  Latency: REQ rises at cycle N in IDLE -> GNT at N+1 -> first ACK at N+1 if not FULL.
//   One dead cycle (IDLE) between bursts.
//  Fairness: a requester re-granted only after all other pending requesters served once.
//  ACK and FIFO_WR_EN never assert together with FIFO_FULL=1. ACK is at most one-hot.
//  REQ changes in BURST for non-granted i have no effect until the next IDLE.
// CONFIGURATION
//  FIFO_ARB_STALL_TIMEOUT_EN defined:
//   - stall_cnt counts consecutive BURST cycles with REQ[g]=0; FULL cycles reset it.
//   - At stall_cnt==STALL_MAX-1: release to IDLE, last_ptr=g, STALL_ERR=1 for one cycle.
//  Not defined: no stall_cnt, STALL_ERR tied 0, grant held until LAST/BURST_MAX.
// STRUCTURE
//  Package fifo_arb_pkg: state enum {IDLE,BURST}, ID width function clog2.
//  Sub-module rr_pick: combinational round-robin picker (req vector, last_ptr -> valid, idx).
//  Top holds FSM, beat/stall counters, output muxing.
// TESTING
//  1 Reset: RST_B=0 two cycles with REQ=4'b1111 -> GNT=0, FIFO_WR_EN=0 throughout.
//    After release, GNT=4'b0001 one cycle later.
//  2 Round robin: REQ=4'b1111, each sends 1 beat with LAST -> grant order 0,1,2,3,0.
//    FIFO_DIN sequence equals requester data.
//  3 Burst cap: req1 holds REQ, no LAST, BURST_MAX=4 -> exactly 4 ACKs, then IDLE.
//    Req2 granted next if pending.
//  4 Full stall: FIFO_FULL=1 for 3 cycles mid-burst -> no ACK/WR_EN those cycles.
//    Burst resumes with beat_cnt preserved; total beats still 4.
//  5 Reset mid-burst: RST_B=0 after 2 beats -> GNT=0 next edge.
//    Post-reset grant restarts at requester 0.
//  6 Timeout (macro on): granted req drops REQ for 8 cycles -> STALL_ERR pulse.
//    Grant passes to next pending requester. Macro off: grant held, STALL_ERR=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// Optional stall timeout is enabled by defining FIFO_ARB_STALL_TIMEOUT_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_ptr.
// Part of fifo_wr_arbiter (see FIFO_ARB_STALL_TIMEOUT_EN in the top).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = NREQ; i >= 1; i--) begin
      j = IW'((int'(last_ptr) + i) % NREQ);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter driving one FIFO write port.
// Define FIFO_ARB_STALL_TIMEOUT_EN to release grants idle for STALL_MAX cycles.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4,
  parameter int STALL_MAX = 8,
  localparam int IW       = clog2(NREQ),
  localparam int BW       = clog2(BURST_MAX) + 1
) (
  input  logic               SYSCLK,
  input  logic               RST_B,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  input  logic [NREQ-1:0]    REQ_LAST,
  input  logic               FIFO_FULL,
  output logic [NREQ-1:0]    GNT,
  output logic [IW-1:0]      GNT_ID,
  output logic [NREQ-1:0]    ACK,
  output logic               FIFO_WR_EN,
  output logic [DW-1:0]      FIFO_DIN,
  output logic               STALL_ERR
);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     id_q, id_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     lp_q, lp_d;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic              req_g;
  logic              beat;
  logic              done;

`ifdef FIFO_ARB_STALL_TIMEOUT_EN
  localparam int SW = clog2(STALL_MAX) + 1;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              serr_q, serr_d;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req      (REQ),
    .last_ptr (lp_q),
    .valid    (pick_vld),
    .idx      (pick_idx)
  );

  assign req_g = REQ[id_q];
  assign beat  = RST_B & (state_q == BURST)
               & req_g & ~FIFO_FULL;
  assign done  = REQ_LAST[id_q]
               | (cnt_q == BW'(BURST_MAX - 1));

  assign GNT        = gnt_q;
  assign GNT_ID     = id_q;
  assign FIFO_WR_EN = beat;
  assign ACK        = beat ? gnt_q : '0;

  always_comb begin
    FIFO_DIN = '0;
    for (int i = 0; i < NREQ; i++)
      if (id_q == IW'(i))
        FIFO_DIN = REQ_DATA[i*DW +: DW];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    lp_d    = lp_q;
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
    scnt_d  = scnt_q;
    serr_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
        scnt_d = '0;
`endif
        if (pick_vld) begin
          state_d = BURST;
          gnt_d   = NREQ'(1) << pick_idx;
          id_d    = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (done) begin
            state_d = IDLE;
            gnt_d   = '0;
            lp_d    = id_q;
          end
        end
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
        // A full FIFO is not the requester's fault, so it restarts the count.
        if (FIFO_FULL || req_g) begin
          scnt_d = '0;
        end else if (scnt_q == SW'(STALL_MAX - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          lp_d    = id_q;
          scnt_d  = '0;
          serr_d  = 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (!RST_B) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      lp_q    <= IW'(NREQ - 1);
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
      scnt_q  <= '0;
      serr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      lp_q    <= lp_d;
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
      scnt_q  <= scnt_d;
      serr_q  <= serr_d;
`endif
    end
  end

`ifdef FIFO_ARB_STALL_TIMEOUT_EN
  assign STALL_ERR = serr_q;
`else
  assign STALL_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Expectations follow FIFO_ARB_STALL_TIMEOUT_EN when defined.
module tb_fifo_wr_arbiter;

  logic        SYSCLK;
  logic        RST_B;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [3:0]  REQ_LAST;
  logic        FIFO_FULL;
  logic [3:0]  GNT;
  logic [1:0]  GNT_ID;
  logic [3:0]  ACK;
  logic        FIFO_WR_EN;
  logic [7:0]  FIFO_DIN;
  logic        STALL_ERR;

  int checks = 0;
  int errors = 0;
  int nack   = 0;

  fifo_wr_arbiter dut (
    .SYSCLK     (SYSCLK),
    .RST_B      (RST_B),
    .REQ        (REQ),
    .REQ_DATA   (REQ_DATA),
    .REQ_LAST   (REQ_LAST),
    .FIFO_FULL  (FIFO_FULL),
    .GNT        (GNT),
    .GNT_ID     (GNT_ID),
    .ACK        (ACK),
    .FIFO_WR_EN (FIFO_WR_EN),
    .FIFO_DIN   (FIFO_DIN),
    .STALL_ERR  (STALL_ERR)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic tick;
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_B     = 1'b0;
    REQ       = 4'b1111;
    REQ_LAST  = 4'b1111;
    FIFO_FULL = 1'b0;
    REQ_DATA  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_gnt", 32'(GNT), 0);
      chk("rst_wr", 32'(FIFO_WR_EN), 0);
      chk("rst_serr", 32'(STALL_ERR), 0);
    end
    RST_B = 1'b1;
    #1;
    chk("idle_gnt", 32'(GNT), 0);
    chk("idle_wr", 32'(FIFO_WR_EN), 0);

    // round robin 0,1,2,3,0 with single-beat bursts
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("rr_gnt", 32'(GNT), 32'(1 << (k % 4)));
      chk("rr_id", 32'(GNT_ID), 32'(k % 4));
      chk("rr_ack", 32'(ACK), 32'(1 << (k % 4)));
      chk("rr_wr", 32'(FIFO_WR_EN), 1);
      chk("rr_din", 32'(FIFO_DIN), 32'(8'hA0 + (k % 4)));
      tick;
      chk("rr_gap_gnt", 32'(GNT), 0);
      chk("rr_gap_wr", 32'(FIFO_WR_EN), 0);
    end

    // burst cap: req1 streams without LAST, req2 waits
    REQ      = 4'b0110;
    REQ_LAST = 4'b0000;
    tick;
    chk("cap_gnt", 32'(GNT), 32'h2);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("cap_ack", 32'(ACK), 32'h2);
      chk("cap_din", 32'(FIFO_DIN), 32'hA1);
      if (ACK[1]) nack++;
      tick;
    end
    chk("cap_beats", 32'(nack), 4);
    chk("cap_idle_gnt", 32'(GNT), 0);
    chk("cap_idle_ack", 32'(ACK), 0);
    tick;
    chk("cap_next_gnt", 32'(GNT), 32'h4);

    // full stall in req2 burst after one beat
    REQ  = 4'b0100;
    nack = 0;
    #1;
    chk("full_b0", 32'(ACK), 32'h4);
    chk("full_din", 32'(FIFO_DIN), 32'hA2);
    if (ACK[2]) nack++;
    tick;
    FIFO_FULL = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("full_ack", 32'(ACK), 0);
      chk("full_wr", 32'(FIFO_WR_EN), 0);
      chk("full_gnt", 32'(GNT), 32'h4);
      tick;
    end
    FIFO_FULL = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("full_resume", 32'(ACK), 32'h4);
      if (ACK[2]) nack++;
      tick;
    end
    chk("full_beats", 32'(nack), 4);
    chk("full_idle", 32'(GNT), 0);

    // reset mid-burst on req3 after two beats
    REQ = 4'b1000;
    tick;
    chk("mr_gnt", 32'(GNT), 32'h8);
    chk("mr_b0", 32'(ACK), 32'h8);
    tick;
    chk("mr_b1", 32'(ACK), 32'h8);
    tick;
    RST_B = 1'b0;
    #1;
    chk("mr_ack_forced", 32'(ACK), 0);
    chk("mr_wr_forced", 32'(FIFO_WR_EN), 0);
    tick;
    chk("mr_gnt_clr", 32'(GNT), 0);
    RST_B    = 1'b1;
    REQ      = 4'b1111;
    REQ_LAST = 4'b1111;
    tick;
    chk("mr_restart", 32'(GNT), 32'h1);
    chk("mr_restart_id", 32'(GNT_ID), 0);
    tick;
    chk("mr_idle", 32'(GNT), 0);

    // idle grant: req1 granted then drops REQ
    REQ      = 4'b0010;
    REQ_LAST = 4'b0000;
    tick;
    chk("to_gnt", 32'(GNT), 32'h2);
    chk("to_b0", 32'(ACK), 32'h2);
    tick;
    REQ = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("to_hold_gnt", 32'(GNT), 32'h2);
      chk("to_hold_ack", 32'(ACK), 0);
      chk("to_hold_serr", 32'(STALL_ERR), 0);
      tick;
    end
`ifdef FIFO_ARB_STALL_TIMEOUT_EN
    chk("to_serr", 32'(STALL_ERR), 1);
    chk("to_rel_gnt", 32'(GNT), 0);
    tick;
    chk("to_serr_pulse", 32'(STALL_ERR), 0);
    chk("to_next_gnt", 32'(GNT), 32'h4);
`else
    chk("lock_serr", 32'(STALL_ERR), 0);
    chk("lock_gnt", 32'(GNT), 32'h2);
    REQ      = 4'b0010;
    REQ_LAST = 4'b0010;
    #1;
    chk("lock_ack", 32'(ACK), 32'h2);
    tick;
    chk("lock_rel", 32'(GNT), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
